// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring CORDIC returning angle (fine and 5-degree code) and magnitude
// Optional build macro CORDIC_VEC_GAIN_COMP_EN: mag is scaled by 155/256 to cancel the CORDIC gain.
module cordic_vectoring #(
  parameter int ITERATIONS = 13
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  output logic        busy,
  output logic        done_out,
  output logic [16:0] angle_fine,
  output logic [6:0]  angle_code,
  output logic [17:0] mag
);

  typedef enum logic [1:0] {IDLE, PRE, ITER, POST} state_t;

  localparam logic [3:0] LAST = 4'(ITERATIONS - 1);

  state_t state, state_next;

  logic signed [17:0] x, y, z;
  logic [3:0]         i;
  logic signed [17:0] xs, ys, dz;
  logic signed [17:0] z_wrap;
  logic [16:0]        z_pos;
  logic [16:0]        code_sum;
  logic [16:0]        code_q;

  // arctan(2^-i) in degrees<<8
  function automatic logic signed [17:0] atan_dz(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_dz = 18'sd11520;
      4'd1:    atan_dz = 18'sd6801;
      4'd2:    atan_dz = 18'sd3593;
      4'd3:    atan_dz = 18'sd1824;
      4'd4:    atan_dz = 18'sd916;
      4'd5:    atan_dz = 18'sd458;
      4'd6:    atan_dz = 18'sd229;
      4'd7:    atan_dz = 18'sd115;
      4'd8:    atan_dz = 18'sd57;
      4'd9:    atan_dz = 18'sd29;
      4'd10:   atan_dz = 18'sd14;
      4'd11:   atan_dz = 18'sd7;
      4'd12:   atan_dz = 18'sd4;
      default: atan_dz = 18'sd0;
    endcase
  endfunction

  assign xs = x >>> i;
  assign ys = y >>> i;
  assign dz = atan_dz(i);

  // Fold negative residual angles into 0..360 degrees, then round to 5-degree steps
  assign z_wrap   = z[17] ? z + 18'sd92160 : z;
  assign z_pos    = 17'(z_wrap);
  assign code_sum = z_pos + 17'd640;
  assign code_q   = code_sum / 17'd1280;

  assign busy = (state != IDLE);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PRE;
      PRE:     state_next = ITER;
      ITER:    if (i == LAST) state_next = POST;
      POST:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      z          <= '0;
      i          <= '0;
      done_out   <= 1'b0;
      angle_fine <= '0;
      angle_code <= '0;
      mag        <= '0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x <= {{2{x_in[15]}}, x_in};
            y <= {{2{y_in[15]}}, y_in};
            z <= '0;
          end
        end
        PRE: begin
          // Left half-plane: rotate by 180 degrees so the iterations converge
          if (x[17]) begin
            x <= -x;
            y <= -y;
            z <= 18'sd46080;
          end
          i <= '0;
        end
        ITER: begin
          if (y[17]) begin
            x <= x - ys;
            y <= y + xs;
            z <= z - dz;
          end else begin
            x <= x + ys;
            y <= y - xs;
            z <= z + dz;
          end
          if (i != LAST) i <= i + 4'd1;
        end
        POST: begin
          done_out <= 1'b1;
          // x never decreases during iteration, so x==0 here means a zero input vector
          if (x == 18'sd0) begin
            angle_fine <= '0;
            angle_code <= '0;
            mag        <= '0;
          end else begin
            angle_fine <= z_pos;
            angle_code <= (code_q == 17'd72) ? 7'd0 : code_q[6:0];
`ifdef CORDIC_VEC_GAIN_COMP_EN
            mag        <= 18'((x * 26'sd155) >>> 8);
`else
            mag        <= x;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cordic_vectoring.md
Name: cordic_vectoring

Overview:
Iterative CORDIC in vectoring mode. It is the inverse of the existing sin/cos rotation block: it takes a signed (x, y) vector and returns the vector's angle and magnitude. The angle is produced in two forms: fine format (degrees<<8, matching the rotation block's dz table scaling) and coarse 7-bit code (5° steps, 0..71, the same encoding as the rotation block's z0 input). Used for round-trip checking of the rotation block and for phase/magnitude extraction.

Parameters:
ITERATIONS, 13, number of micro-rotations; legal range 1..13; the arctan table holds 13 entries.

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
x_in  input  16  signed x component
y_in  input  16  signed y component
busy  output  1  high whenever state != IDLE
done_out  output  1  one-cycle pulse; results valid from this cycle until the next done_out
angle_fine  output  17  unsigned angle, degrees*256, range 0..92159
angle_code  output  7  round(angle/5°) mod 72, range 0..71
mag  output  18  unsigned magnitude, raw or gain-compensated (see Optional Feature)

Behaviour:
- Reset (async, active-high):
  - state=IDLE; busy=0; done_out=0; angle_fine=0; angle_code=0; mag=0.
  - Internal x, y, z and iteration index i are cleared.
- Arctan table, degrees<<8: 11520, 6801, 3593, 1824, 916, 458, 229, 115, 57, 29, 14, 7, 4.
- Datapath widths: x and y are 18-bit signed (growth up to sqrt(2)*1.647); z is 18-bit signed.
- States:
  - IDLE: if start=1, load x=sext(x_in), y=sext(y_in), z=0, then go to PRE. Otherwise hold.
  - PRE (1 cycle): if x<0, set x=-x, y=-y, z=46080 (180°). Set i=0, then go to ITER.
  - ITER (ITERATIONS cycles):
    - d=+1 if y<0, else -1.
    - x<=x-d*(y>>>i); y<=y+d*(x>>>i); z<=z-d*dz[i]. Shifts are arithmetic; all updates use old values.
    - When i==ITERATIONS-1, go to POST. Otherwise i<=i+1.
  - POST (1 cycle):
    - If z<0, z+=92160.
    - angle_fine<=z[16:0].
    - angle_code<=(z+640)/1280. A result of 72 maps to 0.
    - mag<=x (or compensated value).
    - done_out<=1, then go to IDLE.
- Latency: start sampled at edge N → done_out high in the cycle after edge N+2+ITERATIONS (N+15 at default). done_out is cleared at the next edge.
- Throughput: one operation per 3+ITERATIONS cycles. start asserted in the same cycle as done_out is accepted (state is IDLE).
- start while busy=1: ignored; no queuing.
- Inputs x_in and y_in are sampled only at the accepting edge; later changes have no effect.
- Zero vector (x_in=y_in=0): POST forces angle_fine=0, angle_code=0, mag=0.
- Extreme input x_in=-32768: negation is done at 18 bits, so no overflow.
- Result registers hold their values between operations. They are updated only in POST.
- Reset mid-operation: immediate abort to IDLE with all outputs zeroed; no done_out pulse.
- Accuracy at ITERATIONS=13:
  - angle_fine within ±64 (0.25°) of ideal.
  - raw mag within ±0.3% of 1.6468*|v|.

Optional Feature:
Macro CORDIC_VEC_GAIN_COMP_EN.
- Defined: POST computes mag=(x*155)>>>8, i.e. 0.6055, matching the rotation block's 155 pre-scale. This is one 18x8 multiply and 8-bit shift, registered in POST; latency is unchanged.
- Undefined: mag=x raw, which includes the CORDIC gain of about 1.6468; no multiplier is instantiated.
- Angle outputs are identical in both builds.

Test Plan:
- (x,y)=(1000,0), start pulse → done_out exactly 15 cycles later:
  - angle_fine within 0±64 (wrap-aware, i.e. 92096..92159 also accepted); angle_code=0.
  - mag=1647±5 (raw) or 997±5 (GAIN_COMP_EN).
- Quadrants, each with angle_fine ±64:
  - (0,1000) → 23040, code 18.
  - (-1000,0) → 46080, code 36.
  - (0,-1000) → 69120, code 54.
  - (707,707) → 11520, code 9.
- Round-trip: drive the rotation block with each z0 in 0..70 and feed its (cos, sin) here → angle_code==z0 for every value.
- (0,0) → angle_fine=0, angle_code=0, mag=0. Also start held high continuously → back-to-back results every 16 cycles, start during busy ignored.
- Assert reset at ITER i=5 → outputs 0 immediately (async), no done_out. Next start with (-32768,-32768) → angle_fine 57600±64, code 45.
- Angle near 360° boundary, e.g. (1000,-9) → angle_fine ≈ 92028±64, angle_code=0 (wrap of 72).
